// File: rtl/gba_bk_bridge_if.sv
// Purpose : SD block port and DWORD memory port of the GBA backup bridge.
// Latency : none, wiring only.
// Backpr. : SD side is paced by sd_ack; memory side is one request in flight, closed by mem_ack.
// Ports   : master = bridge (drives sd_lba/sd_rd/sd_wr/sd_buff_din and mem_addr/mem_dout/mem_rnw/mem_req),
//           slave  = HPS + memory controller (drives sd_ack/sd_buff_* and mem_din/mem_ack).
interface gba_bk_bridge_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr;
  logic [23:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_rnw;
  logic        mem_req;
  logic        mem_ack;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    output mem_addr, mem_dout, mem_rnw, mem_req,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  mem_din, mem_ack
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  mem_addr, mem_dout, mem_rnw, mem_req,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output mem_din, mem_ack
  );
endinterface

// File: rtl/gba_bk_bridge.sv
// Purpose : moves the backup region between memory and SD blocks (load = SD->mem, save = mem->SD).
// Latency : sd_buff_din 1 cycle after sd_buff_addr; load DWORD write issued 1 cycle after its odd word.
// Backpr. : one memory access in flight; a load DWORD arriving while the holding register is busy is dropped (overflow).
// Ports   : clk_sys, reset_n (sync, active-low), bk_ena/bk_load/bk_save triggers, last_block,
//           bus (gba_bk_bridge_if.master), busy/loading/overflow status.
//           Optional macro GBA_BK_AUTOSAVE_EN adds osd_status, autosave, dirty_we inputs and bk_pending output.
module gba_bk_bridge #(
  parameter int unsigned BASE_ADDR = 65536
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           bk_ena,
  input  logic           bk_load,
  input  logic           bk_save,
  input  logic [14:0]    last_block,
`ifdef GBA_BK_AUTOSAVE_EN
  input  logic           osd_status,
  input  logic           autosave,
  input  logic           dirty_we,
  output logic           bk_pending,
`endif
  output logic           busy,
  output logic           loading,
  output logic           overflow,
  gba_bk_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_XFER, LD_DRAIN, SV_FILL, SV_REQ, SV_XFER
  } state_t;

  localparam logic [23:0] BASE24 = BASE_ADDR[23:0];

  state_t      state;
  logic        load_q, save_q, ack_q;
  logic        pend;          // a memory access is outstanding
  logic [15:0] lo_half;
  logic [7:0]  rd_idx;        // completed fill reads; bit 7 set means all 128 done
  logic [31:0] sv_buf [0:127];

  logic        load_rise, save_rise, ack_rise, ack_fall;
  logic        ack_hit, hold_busy, last_hit, start_save;
  logic [23:0] ld_addr, sv_addr;
  logic [31:0] sv_word;

  assign load_rise = bk_load & ~load_q;
  assign save_rise = bk_save & ~save_q;
  assign ack_rise  = bus.sd_ack & ~ack_q;
  assign ack_fall  = ~bus.sd_ack & ack_q;
  assign ack_hit   = bus.mem_ack & pend;
  // An ack arriving in the same cycle frees the holding register in time.
  assign hold_busy = pend & ~bus.mem_ack;
  assign last_hit  = (bus.sd_lba == {17'd0, last_block});
  assign ld_addr   = BASE24 + {2'b00, bus.sd_lba[14:0], bus.sd_buff_addr[7:1]};
  assign sv_addr   = BASE24 + {2'b00, bus.sd_lba[14:0], rd_idx[6:0]};
  assign sv_word   = sv_buf[bus.sd_buff_addr[7:1]];

`ifdef GBA_BK_AUTOSAVE_EN
  assign start_save = save_rise | (osd_status & autosave & bk_pending);
`else
  assign start_save = save_rise;
`endif

  // Save staging buffer: contents intentionally survive reset.
  always_ff @(posedge clk_sys) begin
    if (reset_n && state == SV_FILL && ack_hit)
      sv_buf[rd_idx[6:0]] <= bus.mem_din;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.sd_lba      <= '0;
      bus.sd_rd       <= 1'b0;
      bus.sd_wr       <= 1'b0;
      bus.sd_buff_din <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_dout    <= '0;
      bus.mem_rnw     <= 1'b1;
      busy            <= 1'b0;
      loading         <= 1'b0;
      overflow        <= 1'b0;
      pend            <= 1'b0;
      lo_half         <= '0;
      rd_idx          <= '0;
      // Preloading the detectors stops a level held through reset looking like an edge.
      load_q          <= bk_load;
      save_q          <= bk_save;
      ack_q           <= bus.sd_ack;
`ifdef GBA_BK_AUTOSAVE_EN
      bk_pending      <= 1'b0;
`endif
    end else begin
      load_q      <= bk_load;
      save_q      <= bk_save;
      ack_q       <= bus.sd_ack;
      bus.mem_req <= 1'b0;
      if (ack_hit)
        pend <= 1'b0;

`ifdef GBA_BK_AUTOSAVE_EN
      if (dirty_we && !busy)
        bk_pending <= 1'b1;
`endif

      if (state == SV_REQ || state == SV_XFER)
        bus.sd_buff_din <= bus.sd_buff_addr[0] ? sv_word[31:16] : sv_word[15:0];

      case (state)
        IDLE: begin
          if (bk_ena && load_rise) begin
            state      <= LD_REQ;
            bus.sd_lba <= '0;
            bus.sd_rd  <= 1'b1;
            busy       <= 1'b1;
            loading    <= 1'b1;
            overflow   <= 1'b0;
          end else if (bk_ena && start_save) begin
            state      <= SV_FILL;
            bus.sd_lba <= '0;
            rd_idx     <= '0;
            busy       <= 1'b1;
            loading    <= 1'b0;
          end
        end

        LD_REQ: begin
          if (ack_rise) begin
            bus.sd_rd <= 1'b0;
            state     <= LD_XFER;
          end
        end

        LD_XFER: begin
          if (bus.sd_buff_wr) begin
            if (!bus.sd_buff_addr[0]) begin
              lo_half <= bus.sd_buff_dout;
            end else if (hold_busy) begin
              overflow <= 1'b1;
            end else begin
              bus.mem_addr <= ld_addr;
              bus.mem_dout <= {bus.sd_buff_dout, lo_half};
              bus.mem_rnw  <= 1'b0;
              bus.mem_req  <= 1'b1;
              pend         <= 1'b1;
            end
          end
          if (ack_fall)
            state <= LD_DRAIN;
        end

        LD_DRAIN: begin
          if (!hold_busy) begin
            if (last_hit) begin
              state   <= IDLE;
              busy    <= 1'b0;
              loading <= 1'b0;
            end else begin
              bus.sd_lba <= bus.sd_lba + 32'd1;
              bus.sd_rd  <= 1'b1;
              state      <= LD_REQ;
            end
          end
        end

        SV_FILL: begin
          if (ack_hit)
            rd_idx <= rd_idx + 8'd1;
          if (!pend && !rd_idx[7]) begin
            bus.mem_addr <= sv_addr;
            bus.mem_rnw  <= 1'b1;
            bus.mem_req  <= 1'b1;
            pend         <= 1'b1;
          end else if (!pend && rd_idx[7]) begin
            bus.sd_wr <= 1'b1;
            state     <= SV_REQ;
          end
        end

        SV_REQ: begin
          if (ack_rise) begin
            bus.sd_wr <= 1'b0;
            state     <= SV_XFER;
          end
        end

        SV_XFER: begin
          if (ack_fall) begin
            if (last_hit) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef GBA_BK_AUTOSAVE_EN
              bk_pending <= 1'b0;
`endif
            end else begin
              bus.sd_lba <= bus.sd_lba + 32'd1;
              rd_idx     <= '0;
              state      <= SV_FILL;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          loading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gba_bk_bridge.sv
// Scoreboard bench for gba_bk_bridge: an HPS model moves SD blocks, a memory model answers
// requests with a programmable latency, and monitors compare memory traffic and save data
// against expectations queued by the stimulus.
module tb_gba_bk_bridge;
  localparam int BASE = 65536;

  logic        clk_sys = 1'b0;
  logic        reset_n, bk_ena, bk_load, bk_save;
  logic [14:0] last_block;
  logic        busy, loading, overflow;
`ifdef GBA_BK_AUTOSAVE_EN
  logic        osd_status, autosave, dirty_we, bk_pending;
`endif

  gba_bk_bridge_if bus();

  gba_bk_bridge #(.BASE_ADDR(BASE)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bk_ena     (bk_ena),
    .bk_load    (bk_load),
    .bk_save    (bk_save),
    .last_block (last_block),
`ifdef GBA_BK_AUTOSAVE_EN
    .osd_status (osd_status),
    .autosave   (autosave),
    .dirty_we   (dirty_we),
    .bk_pending (bk_pending),
`endif
    .busy       (busy),
    .loading    (loading),
    .overflow   (overflow),
    .bus        (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // ---------------- models and expectation queues ----------------
  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] tb_mem [0:511];
  int          mem_lat = 2;
  int          wr_count = 0;
  int          sd_wr_rises = 0;
  logic        sd_wr_prev = 1'b0;
  wr_t         exp_wr_q[$];
  logic [23:0] exp_rd_q[$];
  logic [15:0] exp_din_q[$];
  logic        din_chk = 1'b0;
  logic        din_chk_d = 1'b0;

  // Memory model: acknowledges each request mem_lat cycles later.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
    forever begin
      @(negedge clk_sys);
      if (bus.mem_req === 1'b1) begin
        logic [23:0] a;
        logic [31:0] d;
        logic        rnw;
        int          idx;
        a   = bus.mem_addr;
        d   = bus.mem_dout;
        rnw = bus.mem_rnw;
        idx = (int'(a) - BASE) & 511;
        repeat (mem_lat) @(posedge clk_sys);
        #1;
        bus.mem_ack = 1'b1;
        if (rnw) bus.mem_din = tb_mem[idx];
        else     tb_mem[idx] = d;
        @(posedge clk_sys);
        #1;
        bus.mem_ack = 1'b0;
      end
    end
  end

  // Memory traffic monitor.
  always @(negedge clk_sys) begin
    if (bus.mem_req === 1'b1) begin
      if (!bus.mem_rnw) begin
        wr_count++;
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_mem_write", {8'h0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("mem_write_addr", {8'h0, bus.mem_addr}, {8'h0, e.addr});
          chk("mem_write_data", bus.mem_dout, e.data);
        end
      end else begin
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_mem_read", {8'h0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [23:0] ea;
          ea = exp_rd_q.pop_front();
          chk("mem_read_addr", {8'h0, bus.mem_addr}, {8'h0, ea});
        end
      end
    end
    sd_wr_prev <= bus.sd_wr;
    if (bus.sd_wr === 1'b1 && sd_wr_prev !== 1'b1) sd_wr_rises++;
  end

  // Save data monitor: the value for an address presented in one cycle is checked in the next.
  always @(posedge clk_sys) din_chk_d <= din_chk;
  always @(negedge clk_sys) begin
    if (din_chk_d) begin
      if (exp_din_q.size() == 0) chk("unexpected_sd_buff_din", {16'h0, bus.sd_buff_din}, 32'hFFFF_FFFF);
      else chk("sd_buff_din", {16'h0, bus.sd_buff_din}, {16'h0, exp_din_q.pop_front()});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_load();
    bk_load = 1'b1; tick(2); bk_load = 1'b0; tick();
  endtask

  task automatic pulse_save();
    bk_save = 1'b1; tick(2); bk_save = 1'b0; tick();
  endtask

  task automatic push_reads(input int nblk);
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < 128; i++)
        exp_rd_q.push_back(24'(BASE + b * 128 + i));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin tick(); t++; end
    chk(name, {31'h0, busy}, 32'h0);
  endtask

  // HPS load side: sends 256 words; push_first_only models a stalled memory where
  // every DWORD after the first finds the holding register occupied.
  task automatic hps_load_block(input int lba, input int gap, input bit rnd, input bit push_first_only);
    int t = 0;
    logic [15:0] lo, hi;
    while (bus.sd_rd !== 1'b1 && t < 20000) begin tick(); t++; end
    chk("sd_rd_asserted", {31'h0, bus.sd_rd}, 32'h1);
    chk("load_sd_lba", bus.sd_lba, 32'(lba));
    bus.sd_ack = 1'b1;
    tick(2);
    chk("sd_rd_cleared", {31'h0, bus.sd_rd}, 32'h0);
    for (int a = 0; a < 256; a++) begin
      logic [15:0] w;
      if (a[0] == 1'b0) begin lo = rnd ? 16'($urandom) : 16'h1111; w = lo; end
      else begin hi = rnd ? 16'($urandom) : 16'h2222; w = hi; end
      bus.sd_buff_addr = 8'(a);
      bus.sd_buff_dout = w;
      bus.sd_buff_wr   = 1'b1;
      if (a[0] == 1'b1 && (!push_first_only || a == 1))
        exp_wr_q.push_back('{addr: 24'(BASE + lba * 128 + a / 2), data: {hi, lo}});
      tick();
      bus.sd_buff_wr = 1'b0;
      tick(gap);
    end
    bus.sd_ack = 1'b0;
    tick();
  endtask

  task automatic hps_save_block(input int lba);
    int t = 0;
    while (bus.sd_wr !== 1'b1 && t < 20000) begin tick(); t++; end
    chk("sd_wr_asserted", {31'h0, bus.sd_wr}, 32'h1);
    chk("save_sd_lba", bus.sd_lba, 32'(lba));
    bus.sd_ack = 1'b1;
    tick(2);
    chk("sd_wr_cleared", {31'h0, bus.sd_wr}, 32'h0);
    for (int a = 0; a < 256; a++) begin
      logic [31:0] d;
      d = tb_mem[(lba * 128 + a / 2) & 511];
      bus.sd_buff_addr = 8'(a);
      din_chk = 1'b1;
      exp_din_q.push_back(a[0] ? d[31:16] : d[15:0]);
      tick();
    end
    din_chk    = 1'b0;
    bus.sd_ack = 1'b0;
    tick();
  endtask

  task automatic run_load(input int last, input int gap, input bit rnd);
    last_block = 15'(last);
    pulse_load();
    for (int b = 0; b <= last; b++) hps_load_block(b, gap, rnd, 1'b0);
    wait_idle("load_busy_falls", 2000);
    chk("load_writes_outstanding", exp_wr_q.size(), 0);
    chk("load_overflow_clear", {31'h0, overflow}, 32'h0);
  endtask

  task automatic run_save(input int last);
    last_block = 15'(last);
    push_reads(last + 1);
    pulse_save();
    for (int b = 0; b <= last; b++) hps_save_block(b);
    wait_idle("save_busy_falls", 2000);
    chk("save_reads_outstanding", exp_rd_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; bk_ena = 1'b1; bk_load = 1'b0; bk_save = 1'b0; last_block = '0;
    bus.sd_ack = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0; bus.sd_buff_wr = 1'b0;
`ifdef GBA_BK_AUTOSAVE_EN
    osd_status = 1'b0; autosave = 1'b0; dirty_we = 1'b0;
`endif
    for (int k = 0; k < 512; k++) tb_mem[k] = 32'hDEAD_0000 | 32'(k);
    tick(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_sd_rd_wr", {30'h0, bus.sd_rd, bus.sd_wr}, 32'h0);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_sd_lba", bus.sd_lba, 32'h0);
    chk("rst_sd_buff_din", {16'h0, bus.sd_buff_din}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Triggers ignored while backup is disabled.
    bk_ena = 1'b0;
    pulse_load();
    pulse_save();
    tick(5);
    chk("disabled_no_busy", {31'h0, busy}, 32'h0);
    bk_ena = 1'b1;

    // Fixed-pattern load of one block, then a random two-block load.
    mem_lat = 2;
    run_load(0, 2, 1'b0);
    chk("load_write_count", wr_count, 128);
    chk("load_word_0", tb_mem[0], 32'h2222_1111);
    chk("load_word_127", tb_mem[127], 32'h2222_1111);
    mem_lat = int'($urandom_range(1, 3));
    run_load(1, 2, 1'b1);

    // Save two blocks from a memory holding DWORD k = k; the check of block 1 address 3
    // (high half of DWORD 129) falls out of the same model.
    for (int k = 0; k < 512; k++) tb_mem[k] = 32'(k);
    mem_lat = 2;
    run_save(1);
    chk("save_sd_wr_count", sd_wr_rises, 2);

    // Random save, random latency.
    for (int k = 0; k < 128; k++) tb_mem[k] = $urandom;
    mem_lat = int'($urandom_range(1, 4));
    run_save(0);

    // Stalled memory: only the first DWORD survives, the rest are dropped.
    mem_lat = 300;
    wr_count = 0;
    last_block = '0;
    pulse_load();
    hps_load_block(0, 0, 1'b1, 1'b1);
    chk("overflow_set", {31'h0, overflow}, 32'h1);
    wait_idle("overflow_busy_falls", 2000);
    chk("overflow_write_count", wr_count, 1);
    chk("overflow_sticky", {31'h0, overflow}, 32'h1);

    // Simultaneous load/save edges: load wins, save pulses during the load are dropped.
    mem_lat = 2;
    sd_wr_rises = 0;
    last_block = '0;
    bk_load = 1'b1; bk_save = 1'b1; tick(2); bk_load = 1'b0; bk_save = 1'b0; tick();
    chk("simul_loading", {31'h0, loading}, 32'h1);
    chk("simul_overflow_cleared", {31'h0, overflow}, 32'h0);
    fork
      hps_load_block(0, 2, 1'b1, 1'b0);
      begin tick(40); pulse_save(); tick(100); pulse_save(); end
    join
    wait_idle("simul_busy_falls", 2000);
    tick(300);
    chk("simul_no_save", sd_wr_rises, 0);
    chk("simul_idle_after", {31'h0, busy}, 32'h0);

    // Reset mid SV_XFER, then a fresh save restarts at block 0.
    for (int k = 0; k < 256; k++) tb_mem[k] = $urandom;
    last_block = 15'd1;
    push_reads(2);
    pulse_save();
    begin
      int t = 0;
      while (bus.sd_wr !== 1'b1 && t < 20000) begin tick(); t++; end
      chk("rstx_sd_wr_asserted", {31'h0, bus.sd_wr}, 32'h1);
    end
    bus.sd_ack = 1'b1;
    tick(2);
    for (int a = 0; a < 10; a++) begin
      logic [31:0] d;
      d = tb_mem[a / 2];
      bus.sd_buff_addr = 8'(a);
      din_chk = 1'b1;
      exp_din_q.push_back(a[0] ? d[31:16] : d[15:0]);
      tick();
    end
    din_chk = 1'b0;
    bus.sd_ack = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rstx_sd_wr", {31'h0, bus.sd_wr}, 32'h0);
    chk("rstx_busy", {31'h0, busy}, 32'h0);
    chk("rstx_loading", {31'h0, loading}, 32'h0);
    chk("rstx_sd_lba", bus.sd_lba, 32'h0);
    exp_rd_q.delete();
    tick(5);
    chk("rstx_stays_idle", {31'h0, busy}, 32'h0);
    run_save(0);

`ifdef GBA_BK_AUTOSAVE_EN
    dirty_we = 1'b1; tick(); dirty_we = 1'b0; tick();
    chk("autosave_pending_set", {31'h0, bk_pending}, 32'h1);
    last_block = '0;
    push_reads(1);
    osd_status = 1'b1; autosave = 1'b1;
    hps_save_block(0);
    wait_idle("autosave_busy_falls", 2000);
    chk("autosave_pending_cleared", {31'h0, bk_pending}, 32'h0);
    osd_status = 1'b0; autosave = 1'b0;
`endif

    tick(5);
    chk("final_din_queue_empty", exp_din_q.size(), 0);
    chk("final_wr_queue_empty", exp_wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
